// File: rtl/mcs4_clock_gen.sv
// mcs4_clock_gen
//   Two-phase non-overlapping clock (clk1/clk2) and power-on-clear generator for the
//   MCS-4 bus. It stands in for an i4201 on an FPGA and feeds every i4001/i4002/i4004.
//
//   One period is made of four phases, each timed by an 8-bit down-counter:
//     clk1 high (CLK1_HIGH), gap (GAP12), clk2 high (CLK2_HIGH), gap (GAP21).
//   poc_pad is held high from reset/poc_req through POC_PERIODS full periods. It falls
//   in the same cycle that clk1_pad rises.
//
//   Optional build macro: MCS4_SINGLE_STEP_EN enables single-step hold.
//     A CPU SYNC seen on the last clk2 cycle with run=0 and POC done parks the clocks
//     in the gap before clk1. A step pulse releases one instruction cycle, and run=1 resumes.
//     Without the macro, sync_pad/run/step are ignored and halted is tied low.
//
// Ports
//   sysclk     in   system clock, all flops on rising edge
//   reset      in   synchronous active-high reset
//   poc_req    in   synchronous request to restart power-on clear
//   sync_pad   in   CPU SYNC (single-step only)
//   run        in   1 = free-run, 0 = halt at instruction boundary (single-step only)
//   step       in   one-cycle pulse releasing one instruction cycle while halted
//   clk1_pad   out  phase-1 clock
//   clk2_pad   out  phase-2 clock
//   poc_pad    out  power-on clear
//   clk1_rise  out  strobe in first cycle of each clk1 high
//   clk2_fall  out  strobe in first cycle after clk2 drops
//   halted     out  clocks parked by single-step
module mcs4_clock_gen #(
    parameter int unsigned CLK1_HIGH   = 20,
    parameter int unsigned GAP12       = 14,
    parameter int unsigned CLK2_HIGH   = 20,
    parameter int unsigned GAP21       = 14,
    parameter int unsigned POC_PERIODS = 64
) (
    input  logic sysclk,
    input  logic reset,
    input  logic poc_req,
    input  logic sync_pad,
    input  logic run,
    input  logic step,
    output logic clk1_pad,
    output logic clk2_pad,
    output logic poc_pad,
    output logic clk1_rise,
    output logic clk2_fall,
    output logic halted
);

    localparam logic [7:0] C1Load  = 8'(CLK1_HIGH - 1);
    localparam logic [7:0] G12Load = 8'(GAP12 - 1);
    localparam logic [7:0] C2Load  = 8'(CLK2_HIGH - 1);
    localparam logic [7:0] G21Load = 8'(GAP21 - 1);
    localparam logic [7:0] PocLoad = 8'(POC_PERIODS);

    typedef enum logic [1:0] {
        StC1  = 2'd0,
        StG12 = 2'd1,
        StC2  = 2'd2,
        StG21 = 2'd3
    } phase_e;

    phase_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] poc_cnt_q, poc_cnt_d;
    logic       clk1_pad_q, clk1_pad_d;
    logic       clk2_pad_q, clk2_pad_d;
    logic       poc_pad_q, poc_pad_d;
    logic       clk1_rise_q, clk1_rise_d;
    logic       clk2_fall_q, clk2_fall_d;
    logic       halted_q, halted_d;
    logic       hold;

`ifdef MCS4_SINGLE_STEP_EN
    // park_q remembers the SYNC sample taken on the last clk2 cycle. It is only
    // acted on once the following gap has counted out.
    logic park_q, park_d;
    logic parked;

    always_comb begin
        park_d = park_q;
        if (state_q == StC2 && cnt_q == 8'd0) begin
            park_d = sync_pad;
        end
        parked   = (state_q == StG21) && (cnt_q == 8'd0) && park_q && !run && !poc_pad_q;
        // A step pulse lets the parked FSM advance straight into clk1.
        hold     = parked && !step;
        halted_d = hold;
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            park_q <= 1'b0;
        end else begin
            park_q <= park_d;
        end
    end
`else
    logic unused_step_inputs;
    assign unused_step_inputs = ^{sync_pad, run, step};
    assign hold     = 1'b0;
    assign halted_d = 1'b0;
`endif

    // Phase sequencer: count down, then advance unless held.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
        end else if (!hold) begin
            case (state_q)
                StG21: begin
                    state_d = StC1;
                    cnt_d   = C1Load;
                end
                StC1: begin
                    state_d = StG12;
                    cnt_d   = G12Load;
                end
                StG12: begin
                    state_d = StC2;
                    cnt_d   = C2Load;
                end
                StC2: begin
                    state_d = StG21;
                    cnt_d   = G21Load;
                end
                default: begin
                    state_d = StG21;
                    cnt_d   = G21Load;
                end
            endcase
        end
    end

    // Power-on clear: a request reloads. Otherwise each clk1 rise counts one period.
    // Once the count is spent, the next rise drops poc_pad.
    always_comb begin
        poc_cnt_d = poc_cnt_q;
        poc_pad_d = poc_pad_q;
        if (poc_req) begin
            poc_cnt_d = PocLoad;
            poc_pad_d = 1'b1;
        end else if (state_q == StG21 && state_d == StC1) begin
            if (poc_cnt_q != 8'd0) begin
                poc_cnt_d = poc_cnt_q - 8'd1;
            end else begin
                poc_pad_d = 1'b0;
            end
        end
    end

    // Outputs are decoded from the next state so that they change on the same edge as the state.
    always_comb begin
        clk1_pad_d  = (state_d == StC1);
        clk2_pad_d  = (state_d == StC2);
        clk1_rise_d = (state_q == StG21) && (state_d == StC1);
        clk2_fall_d = (state_q == StC2) && (state_d == StG21);
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state_q     <= StG21;
            cnt_q       <= G21Load;
            poc_cnt_q   <= PocLoad;
            poc_pad_q   <= 1'b1;
            clk1_pad_q  <= 1'b0;
            clk2_pad_q  <= 1'b0;
            clk1_rise_q <= 1'b0;
            clk2_fall_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            poc_cnt_q   <= poc_cnt_d;
            poc_pad_q   <= poc_pad_d;
            clk1_pad_q  <= clk1_pad_d;
            clk2_pad_q  <= clk2_pad_d;
            clk1_rise_q <= clk1_rise_d;
            clk2_fall_q <= clk2_fall_d;
            halted_q    <= halted_d;
        end
    end

    assign clk1_pad  = clk1_pad_q;
    assign clk2_pad  = clk2_pad_q;
    assign poc_pad   = poc_pad_q;
    assign clk1_rise = clk1_rise_q;
    assign clk2_fall = clk2_fall_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_mcs4_clock_gen.sv
`timescale 1ns/1ps
// Bench for mcs4_clock_gen. Three free-running instances are checked each cycle
// against an arithmetic model of the period pattern and the POC count. A fourth,
// small instance exercises single-step (or its absence in the default build).
module tb_mcs4_clock_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_s;
    logic poc_req_b;
    logic run_s;
    logic step_s;
    logic s_sync;
    logic armed = 1'b0;
    int   run_no = 1;
    int   tcnt = 0;
    int   kcnt = 0;
    int   checks = 0;
    int   errors = 0;
    int   rises_a = 0;
    int   rises_b = 0;
    int   rises_c = 0;
    int   seen;
    int   wait_cnt;
    int   k_before;
    logic [3:0] ea, eb, ec;

    logic a_c1, a_c2, a_poc, a_rise, a_fall, a_halt;
    logic b_c1, b_c2, b_poc, b_rise, b_fall, b_halt;
    logic c_c1, c_c2, c_poc, c_rise, c_fall, c_halt;
    logic s_c1, s_c2, s_poc, s_rise, s_fall, s_halt;

    // Defaults, with run=0 and SYNC high. POC never completes here, so no hold may happen.
    mcs4_clock_gen dut_a (
        .sysclk(clk), .reset(rst), .poc_req(1'b0), .sync_pad(1'b1), .run(1'b0),
        .step(1'b1), .clk1_pad(a_c1), .clk2_pad(a_c2), .poc_pad(a_poc),
        .clk1_rise(a_rise), .clk2_fall(a_fall), .halted(a_halt)
    );

    mcs4_clock_gen #(.POC_PERIODS(4)) dut_b (
        .sysclk(clk), .reset(rst), .poc_req(poc_req_b), .sync_pad(1'b0), .run(1'b1),
        .step(1'b0), .clk1_pad(b_c1), .clk2_pad(b_c2), .poc_pad(b_poc),
        .clk1_rise(b_rise), .clk2_fall(b_fall), .halted(b_halt)
    );

    mcs4_clock_gen #(
        .CLK1_HIGH(1), .GAP12(1), .CLK2_HIGH(1), .GAP21(1), .POC_PERIODS(2)
    ) dut_c (
        .sysclk(clk), .reset(rst), .poc_req(1'b0), .sync_pad(1'b0), .run(1'b1),
        .step(1'b0), .clk1_pad(c_c1), .clk2_pad(c_c2), .poc_pad(c_poc),
        .clk1_rise(c_rise), .clk2_fall(c_fall), .halted(c_halt)
    );

    mcs4_clock_gen #(
        .CLK1_HIGH(2), .GAP12(1), .CLK2_HIGH(2), .GAP21(1), .POC_PERIODS(1)
    ) dut_s (
        .sysclk(clk), .reset(rst_s), .poc_req(1'b0), .sync_pad(s_sync), .run(run_s),
        .step(step_s), .clk1_pad(s_c1), .clk2_pad(s_c2), .poc_pad(s_poc),
        .clk1_rise(s_rise), .clk2_fall(s_fall), .halted(s_halt)
    );

    // Stand-in CPU: SYNC is asserted through every 8th clock period.
    always @(posedge clk) begin
        if (rst_s) kcnt <= 0;
        else if (s_rise) kcnt <= kcnt + 1;
    end
    assign s_sync = (kcnt != 0) && (kcnt % 8 == 0);

    always @(posedge clk) begin
        if (rst) tcnt <= 0;
        else tcnt <= tcnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s run=%0d t=%0d actual=%0h expected=%0h", name, run_no, tcnt, act,
                     exp);
        end
    endtask

    // Expected {clk1, clk2, clk1_rise, clk2_fall} t cycles after reset release.
    function automatic logic [3:0] phase_exp(input int c1, input int g12, input int c2,
                                             input int g21, input int t);
        int p;
        logic [3:0] r;
        r = 4'b0000;
        if (t >= g21) begin
            p = (t - g21) % (c1 + g12 + c2 + g21);
            r[3] = (p < c1);
            r[2] = (p >= c1 + g12) && (p < c1 + g12 + c2);
            r[1] = (p == 0);
            r[0] = (p == c1 + g12 + c2);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (armed) begin
            ea = phase_exp(20, 14, 20, 14, tcnt);
            eb = phase_exp(20, 14, 20, 14, tcnt);
            ec = phase_exp(1, 1, 1, 1, tcnt);
            if (ea[1]) rises_a++;
            if (eb[1]) rises_b++;
            if (ec[1]) rises_c++;
            check("a_cycle", int'({a_c1, a_c2, a_poc, a_rise, a_fall, a_halt}),
                  int'({ea[3], ea[2], rises_a < 65, ea[1], ea[0], 1'b0}));
            check("b_cycle", int'({b_c1, b_c2, b_poc, b_rise, b_fall, b_halt}),
                  int'({eb[3], eb[2], rises_b < 5, eb[1], eb[0], 1'b0}));
            check("c_cycle", int'({c_c1, c_c2, c_poc, c_rise, c_fall, c_halt}),
                  int'({ec[3], ec[2], rises_c < 3, ec[1], ec[0], 1'b0}));

            if (run_no == 1) begin
                case (tcnt)
                    13:  check("a_before_first_rise", int'({a_c1, a_rise}), 0);
                    14:  check("a_first_rise", int'({a_c1, a_rise}), 3);
                    33:  check("a_clk1_last", int'(a_c1), 1);
                    34:  check("a_clk1_end", int'(a_c1), 0);
                    48:  check("a_clk2_rise", int'({a_c1, a_c2}), 1);
                    67:  check("a_clk2_last", int'(a_c2), 1);
                    68:  check("a_clk2_fall", int'({a_c2, a_fall}), 1);
                    82:  check("a_second_rise", int'({a_c1, a_rise}), 3);
                    489: check("b_poc_held_by_req", int'(b_poc), 1);
                    490: check("b_poc_falls_8th_rise", int'({b_poc, b_c1}), 1);
                    600: check("a_mid_clk2_at_reset", int'(a_c2), 1);
                    default: ;
                endcase
                case (tcnt)
                    1: check("c_clk1", int'({c_c1, c_c2, c_rise, c_fall}), 4'b1010);
                    2: check("c_gap12", int'({c_c1, c_c2, c_rise, c_fall}), 4'b0000);
                    3: check("c_clk2", int'({c_c1, c_c2, c_rise, c_fall}), 4'b0100);
                    4: check("c_gap21", int'({c_c1, c_c2, c_rise, c_fall}), 4'b0001);
                    8: check("c_poc_high", int'(c_poc), 1);
                    9: check("c_poc_low", int'({c_poc, c_c1}), 1);
                    default: ;
                endcase
            end else begin
                case (tcnt)
                    0:   check("a_after_reset", int'({a_c1, a_c2, a_poc, a_rise, a_fall}),
                               5'b00100);
                    14:  check("a_rise_after_reset", int'({a_c1, a_rise}), 3);
                    285: check("b_poc_before_5th", int'(b_poc), 1);
                    286: check("b_poc_falls_5th_rise", int'({b_poc, b_c1, b_rise}), 3);
                    default: ;
                endcase
            end

            if (rst) begin
                rises_a = 0;
                rises_b = 0;
                rises_c = 0;
            end else if (poc_req_b) begin
                rises_b = 0;
            end
        end
    end

    initial begin
        rst = 1'b1;
        rst_s = 1'b1;
        poc_req_b = 1'b0;
        run_s = 1'b0;
        step_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rst_s = 1'b0;
        armed = 1'b1;
        fork
            begin
                repeat (150) @(posedge clk);
                #1 poc_req_b = 1'b1;
                @(posedge clk);
                #1 poc_req_b = 1'b0;
                repeat (449) @(posedge clk);
                #1 rst = 1'b1;
                @(posedge clk);
                #1;
                rst = 1'b0;
                run_no = 2;
                repeat (320) @(posedge clk);
            end
            begin
                seen = 0;
                wait_cnt = 0;
`ifdef MCS4_SINGLE_STEP_EN
                while (seen == 0 && wait_cnt < 200) begin
                    @(negedge clk);
                    wait_cnt++;
                    if (s_halt) seen = 1;
                end
                check("s_halt_entry", seen, 1);
                check("s_halt_state", int'({s_c1, s_c2, s_poc}), 0);
                check("s_halt_after_8", kcnt, 8);
                repeat (20) @(negedge clk);
                check("s_stays_halted", int'({s_halt, s_c1, s_c2}), 4);
                check("s_no_rise_when_halted", kcnt, 8);
                step_s = 1'b1;
                @(negedge clk);
                step_s = 1'b0;
                check("s_step_release", int'({s_halt, s_c1}), 1);
                seen = 0;
                wait_cnt = 0;
                while (seen == 0 && wait_cnt < 200) begin
                    @(negedge clk);
                    wait_cnt++;
                    if (s_halt) seen = 1;
                end
                check("s_rehalt", seen, 1);
                check("s_step_8_rises", kcnt, 16);
                run_s = 1'b1;
                @(negedge clk);
                check("s_run_resume", int'({s_halt, s_c1}), 1);
                repeat (60) @(negedge clk);
                check("s_free_run", int'({s_halt, kcnt >= 25}), 1);
`else
                while (wait_cnt < 200) begin
                    @(negedge clk);
                    wait_cnt++;
                    if (s_halt) seen = 1;
                end
                check("s_never_halted", seen, 0);
                check("s_clocks_run", int'(kcnt >= 30), 1);
                k_before = kcnt;
                step_s = 1'b1;
                @(negedge clk);
                step_s = 1'b0;
                repeat (60) @(negedge clk);
                check("s_still_running", int'({s_halt, kcnt >= k_before + 9}), 1);
`endif
            end
        join
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
